// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto a single-port byte-wide RAM
//
// Purpose: serialises instruction fetches (always 4 bytes) and load/store
// accesses (1, 2 or 4 bytes) into one-byte-per-cycle RAM accesses and
// assembles little-endian read words.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating grant on contention;
// default build uses fixed MEM-over-IF priority).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req_i/if_addr_i          fetch request and byte address
//   if_flush_i                  aborts a pending or in-flight fetch
//   if_data_o/if_done_o         fetched word and its one-cycle done pulse
//   mem_req_i/mem_we_i          load/store request, 1 = store
//   mem_len_i/mem_addr_i        access length code and byte address
//   mem_wdata_i                 store data (low bytes used)
//   mem_rdata_o/mem_done_o      zero-extended load data and done pulse
//   ram_addr_o/ram_wr_o         RAM byte address and write strobe
//   ram_dout_o/ram_din_i        RAM write byte / read byte (one-cycle latency)
//   busy_o                      high whenever the FSM is not idle
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;        // index of the byte issued this cycle
  logic [1:0]  r_last;       // number of bytes minus one
  logic [23:0] r_wdata;      // remaining store bytes, shifted down as issued
  logic [31:0] r_data;       // read word being assembled
  logic        r_owner_if;
  logic        r_if_done;
  logic [31:0] r_if_data;
  logic        r_mem_done;
  logic [31:0] r_mem_rdata;
  logic [31:0] r_ram_addr;
  logic        r_ram_wr;
  logic [7:0]  r_ram_dout;
`ifdef ARB_ROUND_ROBIN_EN
  logic        r_last_mem;   // 1 when the most recent grant went to MEM
`endif

  logic        w_if_ok;
  logic        w_grant_mem;
  logic        w_grant_if;
  logic [1:0]  w_len_last;
  logic [31:0] w_rd_data;
  logic        w_rd_final;

  assign w_if_ok = if_req_i & ~if_flush_i;
`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_mem = mem_req_i & (~w_if_ok | ~r_last_mem);
`else
  assign w_grant_mem = mem_req_i;
`endif
  assign w_grant_if = w_if_ok & ~w_grant_mem;

  always_comb begin
    case (mem_len_i)
      2'b00:   w_len_last = 2'd0;
      2'b01:   w_len_last = 2'd1;
      default: w_len_last = 2'd3;
    endcase
  end

  // The byte arriving now belongs to the address issued last cycle (r_cnt-1).
  always_comb begin
    w_rd_data = r_data;
    case (r_cnt)
      3'd1:    w_rd_data[7:0]   = ram_din_i;
      3'd2:    w_rd_data[15:8]  = ram_din_i;
      3'd3:    w_rd_data[23:16] = ram_din_i;
      3'd4:    w_rd_data[31:24] = ram_din_i;
      default: w_rd_data = r_data;
    endcase
  end

  assign w_rd_final = (r_cnt == ({1'b0, r_last} + 3'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_last      <= 2'd0;
      r_wdata     <= 24'd0;
      r_data      <= 32'd0;
      r_owner_if  <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_ram_addr  <= 32'd0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_mem  <= 1'b0;
`endif
    end else begin
      // Done pulses and their data last exactly one cycle.
      r_if_done   <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'd0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= 3'd0;
          r_data <= 32'd0;
          if (w_grant_mem) begin
            r_owner_if <= 1'b0;
            r_ram_addr <= mem_addr_i;
            r_last     <= w_len_last;
            r_wdata    <= mem_wdata_i[31:8];
`ifdef ARB_ROUND_ROBIN_EN
            r_last_mem <= 1'b1;
`endif
            if (mem_we_i) begin
              r_ram_wr   <= 1'b1;
              r_ram_dout <= mem_wdata_i[7:0];
              r_state    <= S_MEM_WR;
            end else begin
              r_state    <= S_MEM_RD;
            end
          end else if (w_grant_if) begin
            r_owner_if <= 1'b1;
            r_ram_addr <= if_addr_i;
            r_last     <= 2'd3;
            r_state    <= S_IF_RD;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_mem <= 1'b0;
`endif
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (r_state == S_IF_RD && if_flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_data <= w_rd_data;
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt < {1'b0, r_last})
              r_ram_addr <= r_ram_addr + 32'd1;
            if (w_rd_final) begin
              r_state <= S_DONE;
              if (r_owner_if) begin
                r_if_done <= 1'b1;
                r_if_data <= w_rd_data;
              end else begin
                r_mem_done  <= 1'b1;
                r_mem_rdata <= w_rd_data;
              end
            end
          end
        end
        S_MEM_WR: begin
          if (r_cnt == {1'b0, r_last}) begin
            r_ram_wr   <= 1'b0;
            r_mem_done <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt      <= r_cnt + 3'd1;
            r_ram_addr <= r_ram_addr + 32'd1;
            r_ram_dout <= r_wdata[7:0];
            r_wdata    <= {8'd0, r_wdata[23:8]};
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush arriving in the fetch's DONE cycle still cancels the pulse.
  assign if_done_o   = r_if_done & ~if_flush_i;
  assign if_data_o   = r_if_data;
  assign mem_done_o  = r_mem_done;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wr_o    = r_ram_wr;
  assign ram_dout_o  = r_ram_dout;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:65535];
  logic       init_done = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM: read data for the address of cycle t appears in cycle t+1.
  always @(posedge clk) begin
    if (!init_done) begin
      ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
      ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
      ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22;
      ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
      ram[16'h0030] = 8'h80;
      ram[16'hFFFF] = 8'h34; ram[16'h0000] = 8'h12;
      ram[16'h3001] = 8'h77; ram[16'h3002] = 8'h66; ram[16'h3003] = 8'h55;
      ram[16'h3006] = 8'h01; ram[16'h3007] = 8'h02;
      for (int i = 0; i < 4; i++) ram[16'h2100 + i] = 8'h00;
      init_done <= 1'b1;
    end
    ram_din_i <= ram[ram_addr_o[15:0]];
    if (ram_wr_o) ram[ram_addr_o[15:0]] = ram_dout_o;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, {31'd0, busy_o}, 32'd0);
    chk({nm, " ram_addr"}, ram_addr_o, 32'd0);
    chk({nm, " ram_wr"}, {31'd0, ram_wr_o}, 32'd0);
    chk({nm, " ram_dout"}, {24'd0, ram_dout_o}, 32'd0);
    chk({nm, " if_done"}, {31'd0, if_done_o}, 32'd0);
    chk({nm, " mem_done"}, {31'd0, mem_done_o}, 32'd0);
    chk({nm, " if_data"}, if_data_o, 32'd0);
    chk({nm, " mem_rdata"}, mem_rdata_o, 32'd0);
  endtask

  // Called with the current cycle as cycle 0; returns in the idle cycle after DONE.
  task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int n;
    int dc;
    bit st;
    st = is_mem && we;
    n  = !is_mem ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    dc = st ? n + 1 : n + 2;
    if (is_mem) begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len;
      mem_addr_i = addr; mem_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    for (int c = 1; c <= dc; c++) begin
      cyc();
      chk("busy", {31'd0, busy_o}, 32'd1);
      if (c <= n) begin
        chk("ram_addr", ram_addr_o, addr + 32'(c - 1));
        chk("ram_wr", {31'd0, ram_wr_o}, {31'd0, st});
        if (st) chk("ram_dout", {24'd0, ram_dout_o}, (wdata >> (8 * (c - 1))) & 32'hFF);
      end else begin
        chk("ram_wr quiet", {31'd0, ram_wr_o}, 32'd0);
      end
      if (c < dc) begin
        chk("if_done early", {31'd0, if_done_o}, 32'd0);
        chk("mem_done early", {31'd0, mem_done_o}, 32'd0);
      end else if (is_mem) begin
        chk("mem_done", {31'd0, mem_done_o}, 32'd1);
        chk("if_done in mem done", {31'd0, if_done_o}, 32'd0);
        if (!we) chk("mem_rdata", mem_rdata_o, exp);
        mem_req_i = 1'b0;
      end else begin
        chk("if_done", {31'd0, if_done_o}, 32'd1);
        chk("mem_done in if done", {31'd0, mem_done_o}, 32'd0);
        chk("if_data", if_data_o, exp);
        if_req_i = 1'b0;
      end
    end
    cyc();
    chk("busy after done", {31'd0, busy_o}, 32'd0);
    chk("if_done after", {31'd0, if_done_o}, 32'd0);
    chk("mem_done after", {31'd0, mem_done_o}, 32'd0);
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } txn_t;

  txn_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,          32'h0010_0513};
    tbl[1] = '{1'b1, 1'b1, 2'b11, 32'h0000_2000, 32'hDEAD_BEEF,  32'h0};
    tbl[2] = '{1'b1, 1'b0, 2'b11, 32'h0000_2000, 32'h0,          32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,          32'h0000_1234};
    tbl[4] = '{1'b1, 1'b1, 2'b00, 32'h0000_3000, 32'hAABB_CC5A,  32'h0};
    tbl[5] = '{1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0,          32'h5566_775A};
    tbl[6] = '{1'b1, 1'b1, 2'b01, 32'h0000_3004, 32'h9988_7766,  32'h0};
    tbl[7] = '{1'b1, 1'b0, 2'b11, 32'h0000_3004, 32'h0,          32'h0201_7766};
    tbl[8] = '{1'b1, 1'b0, 2'b00, 32'h0000_2003, 32'h0,          32'h0000_00DE};

    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    repeat (3) cyc();
    chk_all_zero("reset");

    // The first cycle with rst low is already a grant cycle.
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].is_mem, tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Contention: both requests raised in the same idle cycle.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h30;
`ifdef ARB_ROUND_ROBIN_EN
    run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0010_0513);
    run_txn(1'b1, 1'b0, 2'b00, 32'h30, 32'h0, 32'h0000_0080);
`else
    run_txn(1'b1, 1'b0, 2'b00, 32'h30, 32'h0, 32'h0000_0080);
    run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0010_0513);
`endif

    // Flush in idle blocks the fetch grant.
    if_req_i = 1'b1; if_addr_i = 32'h100; if_flush_i = 1'b1;
    cyc();
    chk("flush idle busy", {31'd0, busy_o}, 32'd0);
    if_flush_i = 1'b0;
    // Flush in cycle 2 of a fetch, then refetch from the branch target.
    cyc();
    cyc();
    if_flush_i = 1'b1; if_addr_i = 32'h200;
    cyc();
    chk("flush abort busy", {31'd0, busy_o}, 32'd0);
    chk("flush abort if_done", {31'd0, if_done_o}, 32'd0);
    if_flush_i = 1'b0;
    run_txn(1'b0, 1'b0, 2'b11, 32'h200, 32'h0, 32'h4433_2211);

    // Reset in cycle 2 of a word store.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b11;
    mem_addr_i = 32'h2100; mem_wdata_i = 32'h1122_3344;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk_all_zero("mid-store reset");
    rst = 1'b0; mem_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no mem_done after reset", {31'd0, mem_done_o}, 32'd0);
    end
    chk("reset store byte0", {24'd0, ram[16'h2100]}, 32'h44);
    chk("reset store byte1", {24'd0, ram[16'h2101]}, 32'h33);
    chk("reset store byte2", {24'd0, ram[16'h2102]}, 32'h00);
    chk("reset store byte3", {24'd0, ram[16'h2103]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
